fft_delay_pattern: RTL and testbench

- Self-contained FFT stage-delay block with two parts:
  - a periodic complex test-pattern generator that frames samples into blocks of 2^GEN_LAYER;
  - a write-enabled delay line of depth 2^(DLY_LAYER-1), the buffer length of one radix-2 SDF FFT stage.
- The generator output feeds the delay input internally; both are exposed at the ports.
- Used as the delay/feedback element of a pipelined FFT stage and as its own stimulus source.

---
 rtl/fft_delay_pattern_pkg.sv | 24 ++
 rtl/fft_pattern_src.sv | 65 ++++++
 rtl/fft_delay_pattern.sv | 104 ++++++++++
 tb/tb_fft_delay_pattern.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_delay_pattern_pkg.sv
// Shared types and helpers for the FFT stage-delay block and its pattern source.
package fft_delay_pattern_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    // Complex sample at the default width; `real` is a keyword, hence re/im.
    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] re;
        logic [WIDTH_DEFAULT-1:0] im;
    } sample_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_pattern_src.sv
// Periodic complex test pattern: real = index within a 2^GEN_LAYER frame, imag = frame number.
module fft_pattern_src
    import fft_delay_pattern_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter int unsigned GEN_LAYER = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] gen_real,
    output logic [WIDTH-1:0] gen_img,
    output logic             gen_valid,
    output logic             gen_start,
    output logic             gen_over
);

    // cnt_q holds the index that the output registers take on the next edge.
    logic [GEN_LAYER-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     frame_q, frame_d;
    logic [WIDTH-1:0]     real_q, real_d;
    logic [WIDTH-1:0]     img_q, img_d;
    logic                 valid_q, valid_d;
    logic                 start_q, start_d;
    logic                 over_q, over_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        frame_d = frame_q;
        real_d  = WIDTH'(cnt_q);
        img_d   = frame_q;
        valid_d = 1'b1;
        start_d = (cnt_q == '0);
        over_d  = &cnt_q;
        if (&cnt_q) begin
            frame_d = frame_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            frame_q <= '0;
            real_q  <= '0;
            img_q   <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            real_q  <= real_d;
            img_q   <= img_d;
            valid_q <= valid_d;
            start_q <= start_d;
            over_q  <= over_d;
        end
    end

    assign gen_real  = real_q;
    assign gen_img   = img_q;
    assign gen_valid = valid_q;
    assign gen_start = start_q;
    assign gen_over  = over_q;

endmodule

// File: rtl/fft_delay_pattern.sv
// Pattern source feeding a write-enabled circular delay line of one radix-2 SDF stage.
module fft_delay_pattern
    import fft_delay_pattern_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter int unsigned GEN_LAYER = 4,
    parameter int unsigned DLY_LAYER = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wea,
    output logic [WIDTH-1:0] gen_real,
    output logic [WIDTH-1:0] gen_img,
    output logic             gen_valid,
    output logic             gen_start,
    output logic             gen_over,
    output logic [WIDTH-1:0] dout_real,
    output logic [WIDTH-1:0] dout_img,
    output logic             out_first,
    output logic             out_last
);

    localparam int unsigned DEPTH  = 2 ** (DLY_LAYER - 1);
    localparam int unsigned PTR_W  = clog2(DEPTH);
    localparam int unsigned FILL_W = clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } word_t;

    word_t              mem [DEPTH];
    word_t              wr_word;
    word_t              dout_q, dout_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic               full;

    fft_pattern_src #(
        .WIDTH     (WIDTH),
        .GEN_LAYER (GEN_LAYER)
    ) u_src (
        .clk       (clk),
        .rst       (rst),
        .gen_real  (gen_real),
        .gen_img   (gen_img),
        .gen_valid (gen_valid),
        .gen_start (gen_start),
        .gen_over  (gen_over)
    );

    assign wr_word.re = gen_real;
    assign wr_word.im = gen_img;
    assign full       = (fill_q == FILL_W'(DEPTH));

    // Read-before-write: the slot about to be overwritten holds the sample from DEPTH writes ago.
    always_comb begin
        wptr_d  = wptr_q;
        fill_d  = fill_q;
        dout_d  = dout_q;
        first_d = 1'b0;
        last_d  = 1'b0;
        if (wea) begin
            wptr_d  = wptr_q + 1'b1;
            dout_d  = full ? mem[wptr_q] : '0;
            first_d = full && (wptr_q == '0);
            last_d  = full && (wptr_q == PTR_W'(DEPTH - 1));
            if (!full) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            fill_q  <= '0;
            dout_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            fill_q  <= fill_d;
            dout_q  <= dout_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    // Storage is left unreset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wea) begin
            mem[wptr_q] <= wr_word;
        end
    end

    assign dout_real = dout_q.re;
    assign dout_img  = dout_q.im;
    assign out_first = first_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_fft_delay_pattern.sv
// Randomized bench for fft_delay_pattern against a frame/write-count reference model.
module tb_fft_delay_pattern;
    import fft_delay_pattern_pkg::*;

    localparam int unsigned W = 32;
    localparam int unsigned N = 16;
    localparam int unsigned D = 16;

    logic         clk;
    logic         rst;
    logic         wea;
    logic [W-1:0] gen_real, gen_img, dout_real, dout_img;
    logic         gen_valid, gen_start, gen_over, out_first, out_last;

    int checks = 0;
    int errors = 0;

    // Reference model state: edges since reset release, history of written samples.
    int unsigned edges;
    int unsigned nwrites;
    sample_t     wq[$];
    sample_t     exp_dout;
    logic        exp_first, exp_last;

    logic [2*W+2:0] g_obs, g_exp;
    logic [2*W+1:0] d_obs, d_exp;

    fft_delay_pattern #(
        .WIDTH     (W),
        .GEN_LAYER (4),
        .DLY_LAYER (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wea       (wea),
        .gen_real  (gen_real),
        .gen_img   (gen_img),
        .gen_valid (gen_valid),
        .gen_start (gen_start),
        .gen_over  (gen_over),
        .dout_real (dout_real),
        .dout_img  (dout_img),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Generator output after e edges since release: sample e-1 of the stream, frame-split.
    function automatic sample_t gen_word(input int unsigned e);
        sample_t s;
        s = '0;
        if (e != 0) begin
            s.re = W'((e - 1) % N);
            s.im = W'((e - 1) / N);
        end
        return s;
    endfunction

    function automatic logic [2*W+2:0] gen_exp(input int unsigned e);
        sample_t s;
        s = gen_word(e);
        if (e == 0) return '0;
        return {s.re, s.im, 1'b1, s.re == 0, s.re == W'(N - 1)};
    endfunction

    task automatic model_reset();
        edges     = 0;
        nwrites   = 0;
        wq.delete();
        exp_dout  = '0;
        exp_first = 1'b0;
        exp_last  = 1'b0;
    endtask

    // One clock with the given write enable; leaves time at posedge+1 with the model updated.
    task automatic step(input logic w);
        sample_t pre;
        int unsigned k;
        wea = w;
        pre = gen_word(edges);
        @(posedge clk);
        if (w) begin
            k = nwrites;
            if (k >= D) begin
                exp_dout  = wq[k - D];
                exp_first = (k % D) == 0;
                exp_last  = (k % D) == D - 1;
            end else begin
                exp_dout  = '0;
                exp_first = 1'b0;
                exp_last  = 1'b0;
            end
            wq.push_back(pre);
            nwrites++;
        end else begin
            exp_first = 1'b0;
            exp_last  = 1'b0;
        end
        edges++;
        #1;
        g_obs = {gen_real, gen_img, gen_valid, gen_start, gen_over};
        g_exp = gen_exp(edges);
        d_obs = {dout_real, dout_img, out_first, out_last};
        d_exp = {exp_dout, exp_first, exp_last};
    endtask

    task automatic reset_cycles(input int n);
        wea = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [4*W+4:0] all_out;
        rst = 1'b0;
        wea = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            all_out = {gen_real, gen_img, gen_valid, gen_start, gen_over,
                       dout_real, dout_img, out_first, out_last};
            checks++;
            if (all_out !== '0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h expected 0", i, all_out);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        step(1'b0);
        checks++;
        if (g_obs !== g_exp) begin
            errors++;
            $display("FAIL reset_first_gen: got %h expected %h", g_obs, g_exp);
        end
        checks++;
        if ({gen_valid, gen_start, gen_real, gen_img} !== {1'b1, 1'b1, 64'd0}) begin
            errors++;
            $display("FAIL reset_first_flags: got v=%b s=%b r=%0d i=%0d expected v=1 s=1 r=0 i=0",
                     gen_valid, gen_start, gen_real, gen_img);
        end
    endtask

    task automatic test_free_run();
        int overs;
        overs = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0);
            if (gen_over) overs++;
            checks++;
            if (g_obs !== g_exp) begin
                errors++;
                $display("FAIL free_run_gen[%0d]: got %h expected %h", i, g_obs, g_exp);
            end
            checks++;
            if (d_obs !== '0) begin
                errors++;
                $display("FAIL free_run_dout[%0d]: got %h expected 0", i, d_obs);
            end
        end
        // Edges 2..41 cover n=1..15,0..15,0..8: gen_over twice.
        checks++;
        if (overs != 2) begin
            errors++;
            $display("FAIL free_run_over_count: got %0d expected 2", overs);
        end
    endtask

    task automatic test_write_stream();
        int firsts;
        firsts = 0;
        reset_cycles(2);
        repeat (30) step(1'b0);
        for (int i = 0; i < 100; i++) begin
            step(1'b1);
            if (out_first) firsts++;
            checks++;
            if (g_obs !== g_exp) begin
                errors++;
                $display("FAIL stream_gen[%0d]: got %h expected %h", i, g_obs, g_exp);
            end
            checks++;
            if (d_obs !== d_exp) begin
                errors++;
                $display("FAIL stream_dout[%0d]: got %h expected %h", i, d_obs, d_exp);
            end
        end
        checks++;
        if (firsts != 6) begin
            errors++;
            $display("FAIL stream_first_count: got %0d expected 6", firsts);
        end
    endtask

    task automatic test_toggle();
        reset_cycles(2);
        for (int i = 0; i < 120; i++) begin
            step(i[0] == 1'b0);
            checks++;
            if (d_obs !== d_exp) begin
                errors++;
                $display("FAIL toggle_dout[%0d]: got %h expected %h", i, d_obs, d_exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic seen_flag;
        repeat (20) step(1'b1);
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({gen_valid, dout_real, dout_img, out_first, out_last} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got v=%b dr=%h di=%h f=%b l=%b expected all 0",
                     gen_valid, dout_real, dout_img, out_first, out_last);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen_flag = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1);
            checks++;
            if (d_obs !== d_exp || g_obs !== g_exp) begin
                errors++;
                $display("FAIL midreset_refill[%0d]: got %h/%h expected %h/%h",
                         i, d_obs, g_obs, d_exp, g_exp);
            end
            if (!seen_flag && (out_first || out_last)) begin
                seen_flag = 1'b1;
                checks++;
                if (!(out_first && !out_last && i == 16)) begin
                    errors++;
                    $display("FAIL midreset_first_flag: got f=%b l=%b at write %0d expected f=1 at 16",
                             out_first, out_last, i);
                end
            end
        end
    endtask

    task automatic test_random_wea();
        for (int i = 0; i < 300; i++) begin
            step(($urandom % 3) != 0);
            checks++;
            if (d_obs !== d_exp || g_obs !== g_exp) begin
                errors++;
                $display("FAIL random_wea[%0d]: got %h/%h expected %h/%h",
                         i, d_obs, g_obs, d_exp, g_exp);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        wea = 1'b0;
        model_reset();
        test_reset();
        test_free_run();
        test_write_stream();
        test_toggle();
        test_mid_reset();
        test_random_wea();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
